// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
//   Shared types for the VRAM arbiter: FSM state encoding, arbitration
//   winner encoding and the port ids stored in the read-tag FIFO.
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'd0,
        WIN_REFRESH = 2'd1,
        WIN_A       = 2'd2,
        WIN_B       = 2'd3
    } winner_t;

    // Port id recorded per outstanding read; routes returning data.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/vram_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// vram_arb_tag_fifo
//   1-bit wide FIFO holding the issuing port id of each outstanding read.
//   DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (flushes the FIFO)
//   push, din     write one tag (ignored when full)
//   pop           discard the head tag (ignored when empty)
//   dout          head tag, valid while !empty
//   full, empty   occupancy flags
// ---------------------------------------------------------------------------
module vram_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, so resetting the array only costs logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares the single ip_sdram command port between port A (VDP display /
//   refresh, timing-critical) and port B (command engine / CPU). Enforces a
//   fixed command slot, refresh priority, anti-starvation of B, and routes
//   in-order read data back to the issuing port.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sdram_init_busy              no command is issued while high
//   a_* / b_*                    requester ports (valid/ready handshake,
//                                address, write, wdata, mask, rdata, rdata_en)
//   a_refresh                    refresh request pulse
//   sdram_*                      ip_sdram command/data interface
//   err_orphan                   sticky: read data returned with no tag
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES  = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int TAG_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdram_init_busy,

    input  logic [20:0] a_address,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_write,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wdata_mask,
    input  logic        a_refresh,
    output logic [31:0] a_rdata,
    output logic        a_rdata_en,

    input  logic [20:0] b_address,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_write,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wdata_mask,
    output logic [31:0] b_rdata,
    output logic        b_rdata_en,

    output logic [20:0] sdram_address,
    output logic        sdram_valid,
    output logic        sdram_write,
    output logic        sdram_refresh,
    output logic [31:0] sdram_wdata,
    output logic [3:0]  sdram_wdata_mask,
    input  logic [31:0] sdram_rdata,
    input  logic        sdram_rdata_en,

    output logic        err_orphan
);

    // GAP holds SLOT_CYCLES-2 cycles so ISSUE + GAP + IDLE spans one slot.
    localparam logic [3:0] GAP_LOAD   = 4'(SLOT_CYCLES - 2);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] starve_q;
    logic       refresh_pend_q;
    logic       cmd_refresh_q;
    logic       err_orphan_q;
    winner_t    win;

    logic       a_accept, b_accept;
    logic       grant;
    logic       tag_push, tag_pop, tag_din, tag_dout, tag_full, tag_empty;

    // ---------------- arbitration (IDLE only) ----------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        win = WIN_NONE;
        if (state_q == ST_IDLE && !sdram_init_busy) begin
            if (refresh_pend_q)                        win = WIN_REFRESH;
            else if (b_valid && starve_q == STARVE_MAX) win = WIN_B;
            else if (a_valid)                          win = WIN_A;
            else if (b_valid)                          win = WIN_B;
        end
    end

    // Reads need a free tag slot; writes never do.
    assign a_ready  = (win == WIN_A) && (a_write || !tag_full);
    assign b_ready  = (win == WIN_B) && (b_write || !tag_full);
    assign a_accept = a_valid && a_ready;
    assign b_accept = b_valid && b_ready;
    assign grant    = (win == WIN_REFRESH) || a_accept || b_accept;

    // ---------------- FSM ----------------
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        sdram_valid   = 1'b0;
        sdram_refresh = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                sdram_valid   = !cmd_refresh_q;
                sdram_refresh = cmd_refresh_q;
                if (GAP_LOAD == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q <= 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // ---------------- command register ----------------
    // Loaded on accept; holds its value outside ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdram_address    <= '0;
            sdram_write      <= 1'b0;
            sdram_wdata      <= '0;
            sdram_wdata_mask <= '0;
            cmd_refresh_q    <= 1'b0;
        end else if (a_accept) begin
            sdram_address    <= a_address;
            sdram_write      <= a_write;
            sdram_wdata      <= a_wdata;
            sdram_wdata_mask <= a_wdata_mask;
            cmd_refresh_q    <= 1'b0;
        end else if (b_accept) begin
            sdram_address    <= b_address;
            sdram_write      <= b_write;
            sdram_wdata      <= b_wdata;
            sdram_wdata_mask <= b_wdata_mask;
            cmd_refresh_q    <= 1'b0;
        end else if (win == WIN_REFRESH) begin
            cmd_refresh_q    <= 1'b1;
        end
    end

    // ---------------- refresh, starvation, orphan ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_pend_q <= 1'b0;
            starve_q       <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            // A pulse coinciding with the refresh strobe re-arms the request.
            refresh_pend_q <= a_refresh || (refresh_pend_q && !sdram_refresh);

            if (!b_valid || b_accept)
                starve_q <= '0;
            else if (a_accept && starve_q != STARVE_MAX)
                starve_q <= starve_q + 4'd1;

            if (sdram_rdata_en && tag_empty) err_orphan_q <= 1'b1;
        end
    end

    assign err_orphan = err_orphan_q;

    // ---------------- read tag tracking ----------------
    assign tag_push = (a_accept && !a_write) || (b_accept && !b_write);
    assign tag_din  = b_accept ? PORT_B : PORT_A;
    assign tag_pop  = sdram_rdata_en && !tag_empty;

    vram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tag_push),
        .din     (tag_din),
        .pop     (tag_pop),
        .dout    (tag_dout),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    // Return data is routed in the same cycle it arrives.
    assign a_rdata_en = tag_pop && (tag_dout == PORT_A);
    assign b_rdata_en = tag_pop && (tag_dout == PORT_B);
    assign a_rdata    = sdram_rdata;
    assign b_rdata    = sdram_rdata;

endmodule
